retire_unit: RTL and testbench
==============================

// Module: retire_unit
// PURPOSE
//  Retire (IR) stage: consumer end of the ROB->IR interface. Samples the ROB head packet and commits in order.
//  Drives ir_stall back to the ROB. On each commit it frees t_old, updates the architectural map and
//  performs store writes to memory. Raises a flush (drives ROB/pipeline interrupt) on a taken branch.
//  Stops permanently on halt.
// PARAMETERS
//  CNT_W     64  width of retired-instruction counter
//  XLEN      `XLEN  datapath width (taken from the shared macro, not overridden)
// PORTS
//  clock          in   1               system clock, rising edge
//  reset          in   1               asynchronous, active-high
//  rob_ir_packet  in   ROB_IR_PACKET   head entry: retire_en,retire_t,retire_t_old,inst,halt,wr_mem,dest_reg_idx,NPC,result,rs2_value,take_branch
//  ir_stall       out  1               combinational; ROB advances head only when retire_en && !ir_stall
//  ir_fl_packet   out  IR_FL_PACKET    free_en, free_tag (to free list)
//  ir_map_packet  out  IR_MAP_PACKET   wr_en, reg_idx[4:0], tag (to arch map)
//  mem_req        out  1               store request, level, held until mem_ack
//  mem_addr       out  XLEN            store address (= result)
//  mem_data       out  XLEN            store data (= rs2_value)
//  mem_size       out  2               inst funct3[1:0] (00 B, 01 H, 10 W)
//  mem_ack        in   1               store accepted, single-cycle pulse
//  flush          out  1               1-cycle pulse: squash pipeline, reset ROB
//  redirect_pc    out  XLEN            fetch target, valid with flush (= result)
//  halted         out  1               sticky halt indication
//  retire_count   out  CNT_W           committed instructions, wraps mod 2^CNT_W
// BEHAVIOUR
//  Commit cycle C: retire_en && !ir_stall. All commit outputs are registered and valid in cycle C+1 for exactly one cycle.
//  Reset: state=IDLE; ir_fl/map wr/free_en=0; mem_req=0; mem_addr/data/size=0; flush=0; redirect_pc=0; halted=0; retire_count=0.
//  Reset asserted mid-store drops mem_req immediately. A late mem_ack is ignored.
//  FSM states: IDLE, ST_REQ, ST_DONE, HALTED.
//   IDLE: if retire_en && wr_mem -> ST_REQ, ir_stall=1.
//         If retire_en && !wr_mem, commit with ir_stall=0.
//   ST_REQ: mem_req=1 with addr/data/size latched at entry; ir_stall=1.
//           mem_ack -> ST_DONE.
//           Ack in the first ST_REQ cycle is legal.
//   ST_DONE: ir_stall=0; commit the store; -> IDLE.
//   HALTED: ir_stall=1; halted=1; no commits, no mem_req. Exit only by reset.
//  Per commit:
//   free_en  = t_old.valid; free_tag = t_old.
//   map wr_en = t.valid && dest_reg_idx!=0; reg_idx, tag = dest_reg_idx, t.
//   retire_count increments by 1.
//   halt: commit normally, then -> HALTED. halted rises in C+1.
//   take_branch: flush=1 and redirect_pc=result in C+1.
//  Post-flush blocking: while flush=1 (cycle C+1), ir_stall=1 and no commit occurs, even if retire_en=1.
//   Reason: the ROB head is stale until the flush edge.
//  halt and take_branch together: halt wins; no flush; state -> HALTED.
//  retire_en low in ST_DONE: impossible, since the ROB holds the head while stalled.
//   Implementation asserts this in simulation only.
//  At most one commit per cycle. Counter wrap is silent.
// STRUCTURE
//  Shared package: ROB_IR_PACKET, IR_FL_PACKET, IR_MAP_PACKET, TAG, INST typedefs;
//   retire_state_e enum {IDLE,ST_REQ,ST_DONE,HALTED}; MEM_SIZE encodings.
//  Sub-module retire_store_if: owns ST_REQ/ST_DONE and the mem_req/addr/data/size registers.
//   Returns store_done to the top FSM.
//  Top owns commit decode, the output registers, the counter and the halt/flush logic.
// TESTING
//  1 ALU commit: retire_en=1, t=P33 valid, t_old=P5 valid, dest=3, wr_mem=0
//    -> ir_stall=0 in C; C+1: free_tag=P5, map reg3<-P33, retire_count=1.
//  2 Store: wr_mem=1, result=0x100, rs2=0xDEAD, funct3=010
//    -> ir_stall=1; mem_req with addr=0x100, data=0xDEAD, size=10.
//    mem_ack after 3 cycles -> next cycle ir_stall=0 and commit; mem_req=0.
//  3 Taken branch: take_branch=1, result=0x80
//    -> C+1: flush=1, redirect_pc=0x80, ir_stall=1 despite retire_en=1; count +1 only once.
//  4 Halt: halt=1 -> commit, halted=1 in C+1.
//    Subsequent retire_en=1 for 10 cycles -> ir_stall=1, count unchanged.
//  5 dest_reg_idx=0, t invalid, t_old invalid -> commit with free_en=0, map wr_en=0, count +1.
//  6 Reset asserted in ST_REQ -> mem_req=0 the same cycle, state IDLE.
//    Later mem_ack ignored; back-to-back ALU commits resume.

Source files
------------

// File: rtl/retire_unit_pkg.sv
// Shared types for the retire stage: ROB head packet, free-list and arch-map
// update packets, retire state encoding and memory access sizes.
`ifndef XLEN
`define XLEN 32
`endif

package retire_unit_pkg;

    localparam int XLEN  = `XLEN;
    localparam int PRF_W = 6;

    typedef logic [31:0] INST;

    typedef struct packed {
        logic             valid;
        logic [PRF_W-1:0] idx;
    } TAG;

    typedef struct packed {
        logic            retire_en;
        TAG              retire_t;
        TAG              retire_t_old;
        INST             inst;
        logic            halt;
        logic            wr_mem;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_value;
        logic            take_branch;
    } ROB_IR_PACKET;

    typedef struct packed {
        logic free_en;
        TAG   free_tag;
    } IR_FL_PACKET;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] reg_idx;
        TAG         tag;
    } IR_MAP_PACKET;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        HALTED  = 2'd3
    } retire_state_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } MEM_SIZE;

endpackage

// File: rtl/retire_unit_store_if.sv
// Store handshake for the retire stage: latches the store at start, holds
// mem_req until mem_ack, then reports one ST_DONE cycle so the top can commit.
module retire_store_if
    import retire_unit_pkg::*;
(
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_size,
    input  logic            i_mem_ack,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_data,
    output logic [1:0]      o_mem_size,
    output logic            o_busy,
    output logic            o_store_done
);

    retire_state_e r_state;
    retire_state_e w_nextState;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An ack arriving while IDLE (e.g. after a reset mid-store) is ignored.
    always_comb begin
        w_nextState  = r_state;
        o_mem_req    = 1'b0;
        o_busy       = 1'b0;
        o_store_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_nextState = ST_REQ;
            end
            ST_REQ: begin
                o_mem_req = 1'b1;
                o_busy    = 1'b1;
                if (i_mem_ack) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                o_busy       = 1'b1;
                o_store_done = 1'b1;
                w_nextState  = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_mem_size <= '0;
        end else if (i_start) begin
            o_mem_addr <= i_addr;
            o_mem_data <= i_data;
            o_mem_size <= i_size;
        end
    end

endmodule

// File: rtl/retire_unit.sv
// In-order retire stage: commits the ROB head, frees the old tag, updates the
// arch map, sequences stores, raises flush on taken branches and stops on halt.
module retire_unit
    import retire_unit_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  ROB_IR_PACKET       i_rob_ir_packet,
    output logic               o_ir_stall,
    output IR_FL_PACKET        o_ir_fl_packet,
    output IR_MAP_PACKET       o_ir_map_packet,
    output logic               o_mem_req,
    output logic [XLEN-1:0]    o_mem_addr,
    output logic [XLEN-1:0]    o_mem_data,
    output logic [1:0]         o_mem_size,
    input  logic               i_mem_ack,
    output logic               o_flush,
    output logic [XLEN-1:0]    o_redirect_pc,
    output logic               o_halted,
    output logic [CNT_W-1:0]   o_retire_count
);

    retire_state_e w_state;
    logic          w_storeStart;
    logic          w_storeBusy;
    logic          w_storeDone;
    logic          w_commit;
    logic          w_takeFlush;
    logic          w_unused;

    IR_FL_PACKET   r_flPacket;
    IR_MAP_PACKET  r_mapPacket;
    logic          r_flush;
    logic [XLEN-1:0]  r_redirectPc;
    logic          r_halted;
    logic [CNT_W-1:0] r_count;

    assign w_unused = ^{i_rob_ir_packet.NPC, i_rob_ir_packet.inst[31:14],
                        i_rob_ir_packet.inst[11:0]};

    retire_store_if u_store (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (w_storeStart),
        .i_addr       (i_rob_ir_packet.result),
        .i_data       (i_rob_ir_packet.rs2_value),
        .i_size       (i_rob_ir_packet.inst[13:12]),
        .i_mem_ack    (i_mem_ack),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_size   (o_mem_size),
        .o_busy       (w_storeBusy),
        .o_store_done (w_storeDone)
    );

    // The cycle after a flush the ROB head is stale, so nothing may commit.
    always_comb begin
        w_state      = IDLE;
        o_ir_stall   = 1'b0;
        w_storeStart = 1'b0;
        if (r_halted)         w_state = HALTED;
        else if (w_storeDone) w_state = ST_DONE;
        else if (w_storeBusy) w_state = ST_REQ;
        case (w_state)
            IDLE: begin
                if (r_flush) begin
                    o_ir_stall = 1'b1;
                end else if (i_rob_ir_packet.retire_en && i_rob_ir_packet.wr_mem) begin
                    o_ir_stall   = 1'b1;
                    w_storeStart = 1'b1;
                end
            end
            ST_REQ:  o_ir_stall = 1'b1;
            ST_DONE: o_ir_stall = 1'b0;
            HALTED:  o_ir_stall = 1'b1;
            default: o_ir_stall = 1'b1;
        endcase
    end

    assign w_commit    = i_rob_ir_packet.retire_en && !o_ir_stall;
    assign w_takeFlush = w_commit && i_rob_ir_packet.take_branch && !i_rob_ir_packet.halt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_flPacket   <= '0;
            r_mapPacket  <= '0;
            r_flush      <= 1'b0;
            r_redirectPc <= '0;
            r_halted     <= 1'b0;
            r_count      <= '0;
        end else begin
            r_flPacket  <= '0;
            r_mapPacket <= '0;
            r_flush     <= w_takeFlush;
            if (w_commit) begin
                r_flPacket.free_en   <= i_rob_ir_packet.retire_t_old.valid;
                r_flPacket.free_tag  <= i_rob_ir_packet.retire_t_old;
                r_mapPacket.wr_en    <= i_rob_ir_packet.retire_t.valid &&
                                        (i_rob_ir_packet.dest_reg_idx != 5'd0);
                r_mapPacket.reg_idx  <= i_rob_ir_packet.dest_reg_idx;
                r_mapPacket.tag      <= i_rob_ir_packet.retire_t;
                r_count              <= r_count + CNT_W'(1);
                if (i_rob_ir_packet.halt) r_halted <= 1'b1;
            end
            if (w_takeFlush) r_redirectPc <= i_rob_ir_packet.result;
        end
    end

`ifndef SYNTHESIS
    // The ROB holds its head while stalled, so retire_en cannot drop in ST_DONE.
    headHeldInStDone: assert property (@(posedge i_clock) disable iff (i_reset)
        w_storeDone |-> i_rob_ir_packet.retire_en);
`endif

    assign o_ir_fl_packet  = r_flPacket;
    assign o_ir_map_packet = r_mapPacket;
    assign o_flush         = r_flush;
    assign o_redirect_pc   = r_redirectPc;
    assign o_halted        = r_halted;
    assign o_retire_count  = r_count;

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit: a driver models in-order commit rules and
// queues expected results; a monitor and a memory responder compare them.
module tb_retire_unit;
    import retire_unit_pkg::*;

    typedef struct {
        logic            freeEn;
        TAG              freeTag;
        logic            mapWr;
        logic [4:0]      mapIdx;
        TAG              mapTag;
        logic [63:0]     count;
        logic            flush;
        logic [XLEN-1:0] redirect;
        logic            halted;
    } expect_t;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [1:0]      size;
    } store_t;

    logic            clock = 1'b0;
    logic            reset;
    ROB_IR_PACKET    rob;
    logic            irStall;
    IR_FL_PACKET     flPkt;
    IR_MAP_PACKET    mapPkt;
    logic            memReq;
    logic [XLEN-1:0] memAddr;
    logic [XLEN-1:0] memData;
    logic [1:0]      memSize;
    logic            memAck;
    logic            flush;
    logic [XLEN-1:0] redirectPc;
    logic            halted;
    logic [63:0]     retireCount;

    expect_t expQ[$];
    store_t  storeQ[$];
    int      vectors = 0;
    int      miscompares = 0;

    // reference model state
    bit          mHalted = 0;
    bit          mFlush = 0;
    bit          storeStarted = 0;
    bit          ackGiven = 0;
    bit          autoAck = 1;
    bit          ackPulse = 0;
    bit          reqSeen = 0;
    int          forcedDelay = -1;
    int          ackDelay = 0;
    logic [63:0] mCount = '0;

    retire_unit dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_rob_ir_packet (rob),
        .o_ir_stall      (irStall),
        .o_ir_fl_packet  (flPkt),
        .o_ir_map_packet (mapPkt),
        .o_mem_req       (memReq),
        .o_mem_addr      (memAddr),
        .o_mem_data      (memData),
        .o_mem_size      (memSize),
        .i_mem_ack       (memAck),
        .o_flush         (flush),
        .o_redirect_pc   (redirectPc),
        .o_halted        (halted),
        .o_retire_count  (retireCount)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic ROB_IR_PACKET randPkt();
        ROB_IR_PACKET p;
        p.retire_en          = 1'b1;
        p.retire_t.valid     = 1'($urandom_range(0, 1));
        p.retire_t.idx       = PRF_W'($urandom);
        p.retire_t_old.valid = 1'($urandom_range(0, 1));
        p.retire_t_old.idx   = PRF_W'($urandom);
        p.inst               = $urandom;
        p.inst[13:12]        = 2'($urandom_range(0, 2));
        p.halt               = ($urandom_range(0, 40) == 0);
        p.wr_mem             = ($urandom_range(0, 4) == 0);
        p.dest_reg_idx       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        p.NPC                = XLEN'($urandom);
        p.result             = XLEN'($urandom);
        p.rs2_value          = XLEN'($urandom);
        p.take_branch        = ($urandom_range(0, 6) == 0);
        return p;
    endfunction

    function automatic ROB_IR_PACKET aluPkt(input int tNew, input int tOld, input int dest);
        ROB_IR_PACKET p;
        p = '0;
        p.retire_en          = 1'b1;
        p.retire_t.valid     = 1'b1;
        p.retire_t.idx       = PRF_W'(tNew);
        p.retire_t_old.valid = 1'b1;
        p.retire_t_old.idx   = PRF_W'(tOld);
        p.dest_reg_idx       = 5'(dest);
        return p;
    endfunction

    // One cycle of the in-order commit rules: stalled while halted, during the
    // flush cycle, or while a store is awaiting its ack.
    task automatic stepCycle(input ROB_IR_PACKET p, output bit committed);
        bit      expStall;
        expect_t e;
        @(negedge clock);
        rob = p;
        #2;
        if (mHalted || mFlush)            expStall = 1'b1;
        else if (p.retire_en && p.wr_mem) expStall = !ackGiven;
        else                              expStall = 1'b0;
        if (p.retire_en && p.wr_mem && !mHalted && !mFlush && !storeStarted) begin
            storeQ.push_back('{p.result, p.rs2_value, p.inst[13:12]});
            storeStarted = 1'b1;
        end
        checkOutput("ir_stall", irStall, expStall);
        committed = p.retire_en && !expStall;
        if (committed) begin
            mCount     = mCount + 64'd1;
            e.freeEn   = p.retire_t_old.valid;
            e.freeTag  = p.retire_t_old;
            e.mapWr    = p.retire_t.valid && (p.dest_reg_idx != 5'd0);
            e.mapIdx   = p.dest_reg_idx;
            e.mapTag   = p.retire_t;
            e.count    = mCount;
            e.flush    = p.take_branch && !p.halt;
            e.redirect = p.result;
            mFlush     = e.flush;
            mHalted    = mHalted || p.halt;
            e.halted   = mHalted;
            expQ.push_back(e);
            storeStarted = 1'b0;
            ackGiven     = 1'b0;
        end else begin
            mFlush = 1'b0;
        end
    endtask

    task automatic applyStimulus(input ROB_IR_PACKET p);
        bit c;
        int n;
        c = 1'b0;
        n = 0;
        while (!c && n < 40) begin
            stepCycle(p, c);
            n++;
        end
        if (!c) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL commit_timeout: packet not committed within 40 cycles at %0t", $time);
        end
    endtask

    task automatic bubble(input int n);
        ROB_IR_PACKET b;
        bit c;
        b = randPkt();
        b.retire_en = 1'b0;
        repeat (n) stepCycle(b, c);
    endtask

    task automatic doReset();
        @(negedge clock);
        rob.retire_en = 1'b0;
        #3;
        checkOutput("expq_empty_before_reset", 64'(expQ.size()), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        #4;
        reset = 1'b0;
        mHalted = 0; mFlush = 0; storeStarted = 0; ackGiven = 0; mCount = '0;
        reqSeen = 0; ackPulse = 0; memAck = 1'b0;
        expQ.delete();
        storeQ.delete();
    endtask

    // Monitor: every change of retire_count must match the next expected commit.
    initial begin
        logic [63:0] prevCount;
        expect_t e;
        prevCount = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                checkOutput("rst_count", retireCount, 64'd0);
                checkOutput("rst_flush", flush, 64'd0);
                checkOutput("rst_halted", halted, 64'd0);
                checkOutput("rst_mem_req", memReq, 64'd0);
                checkOutput("rst_mem_addr", memAddr, 64'd0);
                checkOutput("rst_free_en", flPkt.free_en, 64'd0);
                checkOutput("rst_map_wr", mapPkt.wr_en, 64'd0);
                checkOutput("rst_redirect", redirectPc, 64'd0);
                prevCount = '0;
            end else if (retireCount !== prevCount) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_commit: count 0x%0h with nothing expected at %0t", retireCount, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("retire_count", retireCount, e.count);
                    checkOutput("free_en", flPkt.free_en, e.freeEn);
                    if (e.freeEn) checkOutput("free_tag", flPkt.free_tag, e.freeTag);
                    checkOutput("map_wr_en", mapPkt.wr_en, e.mapWr);
                    if (e.mapWr) begin
                        checkOutput("map_reg_idx", mapPkt.reg_idx, e.mapIdx);
                        checkOutput("map_tag", mapPkt.tag, e.mapTag);
                    end
                    checkOutput("flush", flush, e.flush);
                    if (e.flush) checkOutput("redirect_pc", redirectPc, e.redirect);
                    checkOutput("halted", halted, e.halted);
                end
                prevCount = retireCount;
            end else begin
                checkOutput("idle_free_en", flPkt.free_en, 64'd0);
                checkOutput("idle_map_wr", mapPkt.wr_en, 64'd0);
                checkOutput("idle_flush", flush, 64'd0);
            end
        end
    end

    // Memory responder: checks each new store request and acks after a delay.
    initial begin
        store_t s;
        forever begin
            @(negedge clock);
            if (ackPulse) begin
                memAck   = 1'b0;
                ackPulse = 1'b0;
                ackGiven = 1'b1;
            end else if (autoAck && memReq === 1'b1 && !reset) begin
                if (!reqSeen) begin
                    reqSeen = 1'b1;
                    if (storeQ.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_mem_req: addr 0x%0h at %0t", memAddr, $time);
                    end else begin
                        s = storeQ.pop_front();
                        checkOutput("mem_addr", memAddr, s.addr);
                        checkOutput("mem_data", memData, s.data);
                        checkOutput("mem_size", memSize, s.size);
                    end
                    ackDelay = (forcedDelay >= 0) ? forcedDelay : $urandom_range(0, 3);
                end
                if (ackDelay == 0) begin
                    memAck   = 1'b1;
                    ackPulse = 1'b1;
                    reqSeen  = 1'b0;
                end else begin
                    ackDelay--;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ROB_IR_PACKET p;
        bit c;
        reset  = 1'b1;
        rob    = '0;
        memAck = 1'b0;
        repeat (2) @(negedge clock);
        #4;
        reset = 1'b0;

        // ALU commit
        applyStimulus(aluPkt(33, 5, 3));
        // store, ack three cycles after the request
        p = aluPkt(40, 7, 9);
        p.wr_mem = 1'b1; p.result = 32'h100; p.rs2_value = 32'hDEAD; p.inst[14:12] = 3'b010;
        forcedDelay = 3;
        applyStimulus(p);
        // store acked in the first request cycle
        forcedDelay = 0;
        p.result = 32'h104; p.inst[14:12] = 3'b000;
        applyStimulus(p);
        forcedDelay = -1;
        // taken branch, then a follow-on packet that must wait out the flush
        p = aluPkt(12, 13, 4);
        p.take_branch = 1'b1; p.result = 32'h80;
        applyStimulus(p);
        applyStimulus(aluPkt(14, 15, 6));
        // nothing to free or map
        p = aluPkt(0, 0, 0);
        p.retire_t.valid = 1'b0; p.retire_t_old.valid = 1'b0;
        applyStimulus(p);
        // halt together with a taken branch: halt wins, no flush
        p = aluPkt(20, 21, 7);
        p.halt = 1'b1; p.take_branch = 1'b1; p.result = 32'h44;
        applyStimulus(p);
        p = aluPkt(22, 23, 8);
        repeat (10) stepCycle(p, c);
        checkOutput("count_after_halt", retireCount, mCount);
        checkOutput("halted_sticky", halted, 64'd1);
        doReset();

        // reset while a store is waiting for its ack
        autoAck = 1'b0;
        p = aluPkt(30, 31, 2);
        p.wr_mem = 1'b1; p.result = 32'h200; p.rs2_value = 32'hBEEF; p.inst[14:12] = 3'b001;
        @(negedge clock);
        rob = p;
        #2;
        checkOutput("st6_stall", irStall, 64'd1);
        @(negedge clock);
        #2;
        checkOutput("st6_mem_req", memReq, 64'd1);
        checkOutput("st6_mem_addr", memAddr, 64'h200);
        checkOutput("st6_mem_data", memData, 64'hBEEF);
        checkOutput("st6_mem_size", memSize, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("st6_req_drop", memReq, 64'd0);
        @(negedge clock);
        rob.retire_en = 1'b0;
        #4;
        reset = 1'b0;
        mHalted = 0; mFlush = 0; storeStarted = 0; ackGiven = 0; mCount = '0;
        @(negedge clock);
        memAck = 1'b1;
        #2;
        checkOutput("st6_late_ack_req", memReq, 64'd0);
        checkOutput("st6_idle_stall", irStall, 64'd0);
        @(negedge clock);
        memAck  = 1'b0;
        autoAck = 1'b1;
        applyStimulus(aluPkt(50, 51, 10));
        applyStimulus(aluPkt(52, 53, 11));

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) bubble(1);
            applyStimulus(randPkt());
            if (mHalted) begin
                p = randPkt();
                repeat (3) stepCycle(p, c);
                doReset();
            end
        end

        bubble(3);
        checkOutput("expq_drain", 64'(expQ.size()), 64'd0);
        checkOutput("storeq_drain", 64'(storeQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
